// File: rtl/dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding, memory
// geometry, accumulator width and the saturation helpers.
package dot_product_sequencer_pkg;

  localparam int unsigned MEM_DEPTH  = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH);
  localparam int unsigned B_BASE_DEF = 8;
  localparam int unsigned ACC_W      = 19;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_MAC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic acc_overflow(input logic [ACC_W-1:0] acc);
    return acc > ACC_W'(255);
  endfunction

  function automatic logic [DATA_W-1:0] acc_saturate(input logic [ACC_W-1:0] acc);
    return acc_overflow(acc) ? '1 : acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dot_product_sequencer_mac_unit.sv
// Unsigned 8x8 multiply-accumulate with synchronous clear and enable.
module mac_unit
  import dot_product_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences A/B operand reads from the shared memory, accumulates their
// products and publishes a saturated 8-bit dot product with a done pulse.
module dot_product_sequencer
  import dot_product_sequencer_pkg::*;
#(
  parameter int N_ELEM = 8,
  parameter int B_BASE = B_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_compute,
  input  logic              comp_start,
  output logic              comp_done,
  output logic [DATA_W-1:0] comp_result,
  output logic              comp_sat,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   elem_idx_q, elem_idx_d;
  logic [DATA_W-1:0]   a_reg_q, a_reg_d;
  logic                comp_done_q, comp_done_d;
  logic [DATA_W-1:0]   comp_result_q, comp_result_d;
  logic                comp_sat_q, comp_sat_d;
  logic                mac_clr;
  logic                mac_en;
  logic [ACC_W-1:0]    acc;

  mac_unit u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_reg_q),
    .b_i   (mem_rdata),
    .acc_o (acc)
  );

  always_comb begin
    state_d       = state_q;
    elem_idx_d    = elem_idx_q;
    a_reg_d       = a_reg_q;
    comp_done_d   = 1'b0;
    comp_result_d = comp_result_q;
    comp_sat_d    = comp_sat_q;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;
    mem_rd        = 1'b0;
    mem_addr      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (comp_start && mode_compute) begin
          state_d    = ST_RD_A;
          elem_idx_d = '0;
          mac_clr    = 1'b1;
        end
      end
      ST_RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = elem_idx_q;
        state_d  = ST_RD_B;
      end
      ST_RD_B: begin
        a_reg_d  = mem_rdata;
        mem_rd   = 1'b1;
        mem_addr = ADDR_W'(B_BASE) + elem_idx_q;
        state_d  = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (elem_idx_q == ADDR_W'(N_ELEM - 1)) begin
          state_d = ST_DONE;
        end else begin
          elem_idx_d = elem_idx_q + 1'b1;
          state_d    = ST_RD_A;
        end
      end
      ST_DONE: begin
        comp_done_d   = 1'b1;
        comp_result_d = acc_saturate(acc);
        comp_sat_d    = acc_overflow(acc);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the memory grant overrides every state action: drop to IDLE
    // without publishing, leaving the previous result untouched.
    if (state_q != ST_IDLE && !mode_compute) begin
      state_d       = ST_IDLE;
      mac_en        = 1'b0;
      comp_done_d   = 1'b0;
      comp_result_d = comp_result_q;
      comp_sat_d    = comp_sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      elem_idx_q    <= '0;
      a_reg_q       <= '0;
      comp_done_q   <= 1'b0;
      comp_result_q <= '0;
      comp_sat_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      elem_idx_q    <= elem_idx_d;
      a_reg_q       <= a_reg_d;
      comp_done_q   <= comp_done_d;
      comp_result_q <= comp_result_d;
      comp_sat_q    <= comp_sat_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign comp_done   = comp_done_q;
  assign comp_result = comp_result_q;
  assign comp_sat    = comp_sat_q;

endmodule
